// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one imem request per IntMemRead, IR capture on imem_ack (2-cycle min latency,
// fetch_busy stalls the control FSM); FETCH_TIMEOUT_EN adds a 15-cycle REQ timeout with fetch_err.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        IntMemRead,
  input  logic        IRWrite,
  input  logic        ExOp,
  input  logic [15:0] pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        fetch_busy,
  output logic        ir_valid,
  output logic [3:0]  op,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [3:0]  func,
  output logic [15:0] imm_ext,
  output logic [15:0] jmp_off,
  output logic        fetch_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        wr_pend_q, wr_pend_d;
  logic        req_q;
  logic        err_q, err_d;
  logic        timeout;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    wr_pend_d  = wr_pend_q;
    err_d      = 1'b0;
    timeout    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    // The 15th REQ cycle without an ack is the last one; ack in that cycle still wins.
    timeout    = (state_q == REQ) && (cnt_q == 4'd14);
`endif
    case (state_q)
      IDLE: begin
        if (IntMemRead) begin
          state_d   = REQ;
          addr_d    = pc;
          wr_pend_d = IRWrite;
`ifdef FETCH_TIMEOUT_EN
          cnt_d     = 4'd0;
`endif
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (wr_pend_q) begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      wr_pend_q  <= wr_pend_d;
      req_q      <= (state_d == REQ);
      err_q      <= err_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign imem_req   = req_q;
  assign fetch_busy = req_q;
  assign imem_addr  = addr_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_err  = err_q;

  assign op      = ir_q[15:12];
  assign rs      = ir_q[11:8];
  assign rt      = ir_q[7:4];
  assign func    = ir_q[3:0];
  assign imm_ext = ExOp ? {8'h00, ir_q[7:0]} : {{8{ir_q[7]}}, ir_q[7:0]};
  assign jmp_off = {{4{ir_q[11]}}, ir_q[11:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random fetch transactions checked against
// a transaction-level model of IR contents and fetch timing.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        IntMemRead, IRWrite, ExOp, imem_ack;
  logic [15:0] pc, imem_rdata;
  logic        imem_req, fetch_busy, ir_valid, fetch_err;
  logic [15:0] imem_addr, imm_ext, jmp_off;
  logic [3:0]  op, rs, rt, func;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] ir_m;
  logic        vld_m;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .IntMemRead(IntMemRead), .IRWrite(IRWrite), .ExOp(ExOp), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .fetch_busy(fetch_busy), .ir_valid(ir_valid), .op(op), .rs(rs), .rt(rt), .func(func),
    .imm_ext(imm_ext), .jmp_off(jmp_off), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_imm(input logic [15:0] ir, input logic zx);
    int v;
    v = int'(ir[7:0]);
    if (!zx && v >= 128) v = v - 256;
    return 16'(v);
  endfunction

  function automatic logic [15:0] exp_jmp(input logic [15:0] ir);
    int v;
    v = int'(ir[11:0]);
    if (v >= 2048) v = v - 4096;
    return 16'(v);
  endfunction

  task automatic check_decode(input string tag);
    check_eq({tag, "_op"},   op,   32'(ir_m / 4096));
    check_eq({tag, "_rs"},   rs,   32'((ir_m / 256) % 16));
    check_eq({tag, "_rt"},   rt,   32'((ir_m / 16) % 16));
    check_eq({tag, "_func"}, func, 32'(ir_m % 16));
    check_eq({tag, "_vld"},  ir_valid, vld_m);
    check_eq({tag, "_jmp"},  jmp_off, exp_jmp(ir_m));
    check_eq({tag, "_imm"},  imm_ext, exp_imm(ir_m, ExOp));
    ExOp = ~ExOp;
    #1;
    check_eq({tag, "_imm_alt"}, imm_ext, exp_imm(ir_m, ExOp));
  endtask

  // One complete fetch: strobe, 'waits' cycles without ack, then ack with 'data'.
  task automatic do_fetch(input logic [15:0] a, input logic wr, input int waits,
                          input logic [15:0] data, input logic extra);
    IntMemRead = 1'b1; IRWrite = wr; pc = a; imem_ack = 1'b0;
    tick();
    check_eq("busy_start", fetch_busy, 1'b1);
    check_eq("req_start", imem_req, 1'b1);
    check_eq("addr_start", imem_addr, a);
    IntMemRead = 1'b0; IRWrite = 1'($urandom); pc = 16'($urandom);
    for (int k = 0; k < waits; k++) begin
      IntMemRead = extra; pc = 16'($urandom); imem_rdata = 16'($urandom);
      tick();
      check_eq("busy_wait", fetch_busy, 1'b1);
      check_eq("addr_hold", imem_addr, a);
      check_eq("err_wait", fetch_err, 1'b0);
    end
    imem_ack = 1'b1; imem_rdata = data; IntMemRead = extra; pc = 16'($urandom);
    tick();
    if (wr) begin ir_m = data; vld_m = 1'b1; end
    check_eq("busy_done", fetch_busy, 1'b0);
    check_eq("req_done", imem_req, 1'b0);
    check_eq("err_done", fetch_err, 1'b0);
    check_decode("cap");
    imem_ack = 1'b0; IntMemRead = 1'b0;
    tick();
    check_eq("busy_after", fetch_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; IntMemRead = 1'b0; IRWrite = 1'b0; ExOp = 1'b0; imem_ack = 1'b0;
    pc = 16'h0000; imem_rdata = 16'h0000;
    ir_m = 16'h0000; vld_m = 1'b0;
    #12;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_busy", fetch_busy, 1'b0);
    check_eq("rst_addr", imem_addr, 16'h0000);
    check_eq("rst_err", fetch_err, 1'b0);
    check_decode("rst");
    rst = 1'b1;
    tick();

    // Zero-wait fetch.
    ExOp = 1'b0;
    do_fetch(16'h0010, 1'b1, 0, 16'h8123, 1'b0);
    check_eq("zw_op", op, 4'h8);
    check_eq("zw_rs", rs, 4'h1);
    check_eq("zw_rt", rt, 4'h2);
    check_eq("zw_func", func, 4'h3);

    // Three wait states with an extra strobe that must be ignored.
    do_fetch(16'h0200, 1'b1, 3, 16'h4567, 1'b1);

    // Extension cases.
    do_fetch(16'h0300, 1'b1, 1, 16'h9AF0, 1'b0);
    ExOp = 1'b0; #1;
    check_eq("imm_sign", imm_ext, 16'hFFF0);
    ExOp = 1'b1; #1;
    check_eq("imm_zero", imm_ext, 16'h00F0);
    check_eq("jmp_9af0", jmp_off, 16'hFAF0);

    // IRWrite=0 leaves IR alone.
    do_fetch(16'h0400, 1'b0, 1, 16'h1234, 1'b0);
    check_eq("nowr_func", func, 4'h0);

    // Ack while idle is ignored.
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    imem_ack = 1'b0;
    check_eq("idle_ack_busy", fetch_busy, 1'b0);
    check_decode("idle_ack");

    // Reset mid-fetch.
    IntMemRead = 1'b1; IRWrite = 1'b1; pc = 16'hBEEF;
    tick();
    IntMemRead = 1'b0;
    check_eq("mid_busy", fetch_busy, 1'b1);
    #2; rst = 1'b0; #1;
    ir_m = 16'h0000; vld_m = 1'b0;
    check_eq("arst_req", imem_req, 1'b0);
    check_eq("arst_busy", fetch_busy, 1'b0);
    check_eq("arst_addr", imem_addr, 16'h0000);
    check_decode("arst");
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    check_eq("late_ack_busy", fetch_busy, 1'b0);
    check_decode("late_ack");

    // Random fetch transactions.
    for (int i = 0; i < 40; i++) begin
      ExOp = 1'($urandom);
      do_fetch(16'($urandom), 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)),
               16'($urandom), 1'($urandom));
    end

`ifdef FETCH_TIMEOUT_EN
    // No ack: 15 REQ cycles, then fetch_err for one cycle back in IDLE.
    IntMemRead = 1'b1; IRWrite = 1'b1; pc = 16'h0777;
    tick();
    IntMemRead = 1'b0;
    check_eq("to_busy0", fetch_busy, 1'b1);
    for (int k = 0; k < 14; k++) begin
      tick();
      check_eq("to_busy", fetch_busy, 1'b1);
      check_eq("to_noerr", fetch_err, 1'b0);
    end
    tick();
    check_eq("to_idle", fetch_busy, 1'b0);
    check_eq("to_err", fetch_err, 1'b1);
    tick();
    check_eq("to_err_pulse", fetch_err, 1'b0);
    check_decode("to_ir");
    // Ack in the 15th REQ cycle wins over the timeout.
    do_fetch(16'h0888, 1'b1, 14, 16'hC3A5, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-low.
REQ-002 The block SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL provide port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port IntMemRead, input, 1 bit: fetch request strobe from the control FSM.
REQ-005 The block SHALL provide port IRWrite, input, 1 bit: enables IR capture for the fetch launched in the same cycle.
REQ-006 The block SHALL provide port ExOp, input, 1 bit: immediate extension mode, 0 = sign, 1 = zero.
REQ-007 The block SHALL provide port pc, input, 16 bits: fetch address.
REQ-008 The block SHALL provide port imem_req, output, 1 bit: instruction memory request.
REQ-009 The block SHALL provide port imem_addr, output, 16 bits: latched fetch address.
REQ-010 The block SHALL provide port imem_ack, input, 1 bit: memory returns imem_rdata valid this cycle.
REQ-011 The block SHALL provide port imem_rdata, input, 16 bits: instruction word.
REQ-012 The block SHALL provide port fetch_busy, output, 1 bit: fetch outstanding, the FSM stalls.
REQ-013 The block SHALL provide port ir_valid, output, 1 bit: IR holds a fetched instruction.
REQ-014 The block SHALL provide port op, output, 4 bits: IR[15:12].
REQ-015 The block SHALL provide port rs, output, 4 bits: IR[11:8].
REQ-016 The block SHALL provide port rt, output, 4 bits: IR[7:4].
REQ-017 The block SHALL provide port func, output, 4 bits: IR[3:0].
REQ-018 The block SHALL provide port imm_ext, output, 16 bits: IR[7:0] extended per ExOp.
REQ-019 The block SHALL provide port jmp_off, output, 16 bits: IR[11:0] sign-extended.
REQ-020 The block SHALL provide port fetch_err, output, 1 bit: one-cycle timeout pulse.

Function
REQ-021 The block SHALL implement a two-state FSM with states IDLE and REQ.
REQ-022 In IDLE with IntMemRead=1, the block SHALL, at the clock edge, latch pc into imem_addr, latch IRWrite into wr_pend, and enter REQ.
REQ-023 In IDLE with IntMemRead=0, the block SHALL remain in IDLE.
REQ-024 imem_req and fetch_busy SHALL be registered and SHALL equal 1 exactly while in REQ.
REQ-025 In REQ with imem_ack=1: the block SHALL load IR from imem_rdata and set ir_valid when wr_pend=1, then return to IDLE.
REQ-026 In REQ with imem_ack=1 and wr_pend=0, the block SHALL leave IR and ir_valid unchanged and SHALL return to IDLE.
REQ-027 Zero-wait memory (imem_ack in the first REQ cycle) SHALL give 2-cycle latency: the IntMemRead edge, then the capture edge.
REQ-028 Each additional cycle without imem_ack SHALL add one cycle of latency.
REQ-029 IntMemRead asserted while in REQ SHALL be ignored, and imem_addr SHALL be unchanged.
REQ-030 An IntMemRead arriving in the same cycle as the completing imem_ack SHALL be ignored; the FSM SHALL re-pulse it after fetch_busy falls.
REQ-031 imem_ack in IDLE SHALL be ignored.
REQ-032 op, rs, rt, func, imm_ext and jmp_off SHALL be combinational from IR and ExOp.
REQ-033 op, rs, rt, func, imm_ext and jmp_off SHALL be stable between captures.
REQ-034 imm_ext SHALL be {8{IR[7]},IR[7:0]} when ExOp=0 and {8'h00,IR[7:0]} when ExOp=1.
REQ-035 jmp_off SHALL be {4{IR[11]},IR[11:0]}.

Reset
REQ-036 On rst=0, the block SHALL immediately set state to IDLE and clear imem_req, fetch_busy, imem_addr, IR, ir_valid, wr_pend, fetch_err and the timeout counter; no clock is required.
REQ-037 Reset mid-fetch SHALL abort the fetch, drop imem_req in the same cycle, and leave IR at 16'h0000.
REQ-038 A late imem_ack after reset release SHALL be ignored.
REQ-039 After reset release, the first IntMemRead SHALL start a fetch normally.

Configuration
REQ-040 With macro FETCH_TIMEOUT_EN defined, the block SHALL count cycles in REQ with a 4-bit counter that is cleared on entry to REQ.
REQ-041 With FETCH_TIMEOUT_EN defined, if the counter reaches 15 without imem_ack, the block SHALL return to IDLE, drop imem_req, leave IR and ir_valid unchanged, and pulse fetch_err for one cycle.
REQ-042 With FETCH_TIMEOUT_EN defined, imem_ack in the same cycle the counter reaches 15 SHALL win, giving a normal capture and no fetch_err.
REQ-043 Without FETCH_TIMEOUT_EN, the block SHALL have no counter, SHALL wait in REQ indefinitely, and SHALL tie fetch_err to 0.

Verification
REQ-044 The bench SHALL cover zero-wait fetch: pc=16'h0010, IntMemRead=IRWrite=1, imem_ack in the first REQ cycle with rdata=16'h8123 -> op=4'h8, rs=1, rt=2, func=3, ir_valid=1, two edges after the strobe.
REQ-045 The bench SHALL cover wait states: imem_ack delayed 3 cycles -> fetch_busy high for 4 cycles, imem_addr held, and a second IntMemRead during the wait ignored.
REQ-046 The bench SHALL cover extension: IR=16'h9AF0 -> imm_ext=16'hFFF0 with ExOp=0, 16'h00F0 with ExOp=1, and jmp_off=16'hFAF0.
REQ-047 The bench SHALL cover reset mid-fetch: rst=0 while in REQ -> imem_req=0 asynchronously and IR=0; an ack after release changes nothing.
REQ-048 The bench SHALL cover the IRWrite=0 fetch: ack with rdata=16'h1234 -> IR unchanged and busy cleared.
REQ-049 The bench SHALL cover timeout with FETCH_TIMEOUT_EN: no ack -> fetch_err pulses 1 cycle after 15 REQ cycles, then IDLE; ack at cycle 15 -> capture with no error.
